sqrt_job_dispatcher: RTL and testbench

- Upstream and downstream wrapper for the SqrtFloatingPoint core.
- Buffers square-root requests (64-bit integer or 32-bit float) in a small FIFO.
- Launches one job at a time on the core's isInputStable/isResultStable/resultAck handshake.
- Holds each result in a response register with a valid/ready interface, so callers never drive the core's pulse protocol directly.

---
 rtl/sqrt_pkg.sv | 25 ++
 rtl/sqrt_req_fifo.sv | 71 +++++++
 rtl/sqrt_job_dispatcher.sv | 131 +++++++++++++
 tb/tb_sqrt_job_dispatcher.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for users of the SqrtFloatingPoint core:
//   - default operand/result widths
//   - dispatcher FSM state encoding
//   - request record {isFloat, data} as carried through request queues
// ---------------------------------------------------------------------------
package sqrt_pkg;

  localparam int SIZE_DEFAULT       = 64;
  localparam int FLOAT_SIZE_DEFAULT = 32;

  // Dispatcher FSM encoding (fixed values so traces stay comparable).
  typedef logic [1:0] sqrt_state_t;
  localparam sqrt_state_t ST_IDLE   = 2'd0;
  localparam sqrt_state_t ST_LAUNCH = 2'd1;
  localparam sqrt_state_t ST_WAIT   = 2'd2;
  localparam sqrt_state_t ST_ACK    = 2'd3;

  typedef struct packed {
    logic                    isFloat;
    logic [SIZE_DEFAULT-1:0] data;
  } sqrt_req_t;

endpackage

// File: rtl/sqrt_req_fifo.sv
// ---------------------------------------------------------------------------
// sqrt_req_fifo
// Small synchronous FIFO holding pending square-root requests.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push, din : write din when push is high and the FIFO is not full
//   pop       : drop the head entry when pop is high and the FIFO is not empty
//   full      : DEPTH entries stored
//   empty     : no entries stored
//   head      : oldest entry (valid while !empty), read combinationally so
//               the dispatcher can pop and capture in the same cycle
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sqrt_req_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == FULL_COUNT);
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage kept out of the reset branch so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_job_dispatcher.sv
// ---------------------------------------------------------------------------
// sqrt_job_dispatcher
// Wraps the SqrtFloatingPoint core: queues requests, launches one job at a
// time on the core's pulse handshake and parks each result in a
// valid/ready response register.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   reqValid/reqReady/reqData/reqIsFloat : request side (reqReady = FIFO not full)
//   coreIn/coreIsFloat            : operand to the core, held LAUNCH..ACK
//   coreInputStable               : one-cycle launch pulse (LAUNCH state)
//   coreResult/coreResultStable   : result from the core
//   coreResultAck                 : acknowledge, high throughout ACK
//   respValid/respReady/respData/respIsFloat : response side
//   busy                          : FSM active or requests pending
// ---------------------------------------------------------------------------
module sqrt_job_dispatcher
  import sqrt_pkg::*;
#(
  parameter int SIZE       = SIZE_DEFAULT,
  parameter int FLOAT_SIZE = FLOAT_SIZE_DEFAULT,
  parameter int DEPTH      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reqValid,
  output logic            reqReady,
  input  logic [SIZE-1:0] reqData,
  input  logic            reqIsFloat,
  output logic [SIZE-1:0] coreIn,
  output logic            coreIsFloat,
  output logic            coreInputStable,
  input  logic [SIZE-1:0] coreResult,
  input  logic            coreResultStable,
  output logic            coreResultAck,
  output logic            respValid,
  input  logic            respReady,
  output logic [SIZE-1:0] respData,
  output logic            respIsFloat,
  output logic            busy
);

  // Keeps only the float payload bits; upper bits of float words are junk.
  localparam logic [SIZE-1:0] FLOAT_MASK =
    {{(SIZE-FLOAT_SIZE){1'b0}}, {FLOAT_SIZE{1'b1}}};

  sqrt_state_t     r_state;
  sqrt_state_t     w_state_next;
  logic [SIZE-1:0] r_core_in;
  logic            r_core_is_float;
  logic            r_resp_valid;
  logic [SIZE-1:0] r_resp_data;
  logic            r_resp_is_float;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [SIZE:0]   w_fifo_din;
  logic [SIZE:0]   w_fifo_head;
  logic            w_capture;

  assign reqReady   = !w_full;
  assign w_push     = reqValid && !w_full;
  assign w_fifo_din = {reqIsFloat, reqIsFloat ? (reqData & FLOAT_MASK) : reqData};

  // A new job only starts once the previous result has been collected, so
  // the response register can never be overwritten.
  assign w_pop     = (r_state == ST_IDLE) && !w_empty && !r_resp_valid;
  assign w_capture = (r_state == ST_WAIT) && coreResultStable;

  sqrt_req_fifo #(
    .WIDTH (SIZE + 1),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_fifo_din),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_fifo_head)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_pop) w_state_next = ST_LAUNCH;
      ST_LAUNCH: w_state_next = ST_WAIT;
      ST_WAIT:   if (coreResultStable) w_state_next = ST_ACK;
      // Hold the ack until the core withdraws its result, otherwise a
      // lingering isResultStable could be mistaken for a new result.
      ST_ACK:    if (!coreResultStable) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_core_in       <= '0;
      r_core_is_float <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_resp_data     <= '0;
      r_resp_is_float <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_core_in       <= w_fifo_head[SIZE-1:0];
        r_core_is_float <= w_fifo_head[SIZE];
      end
      if (w_capture) begin
        r_resp_data     <= r_core_is_float ? (coreResult & FLOAT_MASK) : coreResult;
        r_resp_is_float <= r_core_is_float;
        r_resp_valid    <= 1'b1;
      end else if (r_resp_valid && respReady) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign coreIn          = r_core_in;
  assign coreIsFloat     = r_core_is_float;
  assign coreInputStable = (r_state == ST_LAUNCH);
  assign coreResultAck   = (r_state == ST_ACK);
  assign respValid       = r_resp_valid;
  assign respData        = r_resp_data;
  assign respIsFloat     = r_resp_is_float;
  assign busy            = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_sqrt_job_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_sqrt_job_dispatcher
// Directed bench for sqrt_job_dispatcher with a behavioural core model of
// programmable latency and result-hold time.
// ---------------------------------------------------------------------------
module tb_sqrt_job_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic [63:0] reqData;
  logic        reqIsFloat;
  logic [63:0] coreIn;
  logic        coreIsFloat;
  logic        coreInputStable;
  logic [63:0] coreResult;
  logic        coreResultStable;
  logic        coreResultAck;
  logic        respValid;
  logic        respReady;
  logic [63:0] respData;
  logic        respIsFloat;
  logic        busy;

  logic core_stable;
  logic force_stable;
  assign coreResultStable = core_stable | force_stable;

  always #5 clk = ~clk;

  sqrt_job_dispatcher dut (
    .clk              (clk),
    .rst              (rst),
    .reqValid         (reqValid),
    .reqReady         (reqReady),
    .reqData          (reqData),
    .reqIsFloat       (reqIsFloat),
    .coreIn           (coreIn),
    .coreIsFloat      (coreIsFloat),
    .coreInputStable  (coreInputStable),
    .coreResult       (coreResult),
    .coreResultStable (coreResultStable),
    .coreResultAck    (coreResultAck),
    .respValid        (respValid),
    .respReady        (respReady),
    .respData         (respData),
    .respIsFloat      (respIsFloat),
    .busy             (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural core ----------------
  int          core_lat   = 10;
  int          core_extra = 0;
  int          core_phase = 0;
  int          core_cnt   = 0;
  int          core_hold  = 0;

  function automatic logic [63:0] core_calc(input logic [63:0] x, input logic f);
    logic [63:0] r;
    r = 64'd0;
    if (f) begin
      // Float results carry junk in the upper half on purpose.
      case (x[31:0])
        32'h4080_0000: r = {32'hDEAD_BEEF, 32'h4000_0000};
        32'h4180_0000: r = {32'hDEAD_BEEF, 32'h4080_0000};
        default:       r = {32'hDEAD_BEEF, 32'h0000_0000};
      endcase
    end else begin
      while ((r + 64'd1) * (r + 64'd1) <= x) r = r + 64'd1;
    end
    return r;
  endfunction

  initial begin
    core_stable  = 1'b0;
    force_stable = 1'b0;
    coreResult   = 64'd0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        core_phase  = 0;
        core_stable = 1'b0;
      end else begin
        case (core_phase)
          0: if (coreInputStable) begin
               coreResult = core_calc(coreIn, coreIsFloat);
               core_cnt   = core_lat;
               core_phase = 1;
             end
          1: begin
               core_cnt--;
               if (core_cnt <= 0) begin
                 core_stable = 1'b1;
                 core_phase  = 2;
               end
             end
          2: if (coreResultAck) begin
               if (core_extra == 0) begin
                 core_stable = 1'b0;
                 core_phase  = 0;
               end else begin
                 core_hold  = core_extra;
                 core_phase = 3;
               end
             end
          3: begin
               core_hold--;
               if (core_hold <= 0) begin
                 core_stable = 1'b0;
                 core_phase  = 0;
               end
             end
          default: core_phase = 0;
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  int          launch_cnt = 0;
  int          ack_cycles = 0;
  int          resp_rises = 0;
  int          stable_run = 0;
  logic        prev_rv    = 1'b0;
  logic [64:0] resp_q [$];

  initial forever begin
    @(negedge clk); #1;
    if (coreInputStable) begin
      if (stable_run == 0) launch_cnt++;
      stable_run++;
    end else begin
      stable_run = 0;
    end
    if (coreResultAck) ack_cycles++;
    if (respValid && !prev_rv) resp_rises++;
    prev_rv = respValid;
    if (respValid && respReady) begin
      resp_q.push_back({respIsFloat, respData});
      $display("RESP isFloat=%0b data=%h", respIsFloat, respData);
    end
  end

  // ---------------- helpers ----------------
  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send(input logic [63:0] d, input logic f);
    int n;
    n = 0;
    reqValid   = 1'b1;
    reqData    = d;
    reqIsFloat = f;
    while (!reqReady && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady) check_eq("send_timeout", {64'd0, reqReady}, 65'd1);
    @(negedge clk);
    $display("REQ  isFloat=%0b data=%h", f, d);
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (!respValid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!respValid) check_eq(tag, {64'd0, respValid}, 65'd1);
  endtask

  task automatic take_resp();
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
  endtask

  task automatic check_reset(input string p);
    check_eq({p, "_reqReady"}, {64'd0, reqReady}, 65'd1);
    check_eq({p, "_coreIn"}, {1'b0, coreIn}, 65'd0);
    check_eq({p, "_respData"}, {1'b0, respData}, 65'd0);
    check_eq({p, "_ctrl"},
             {59'd0, coreIsFloat, coreInputStable, coreResultAck, respValid, respIsFloat, busy},
             65'd0);
  endtask

  logic [63:0] t3_data [6] = '{64'd16, 64'd25, 64'h0000_0000_4180_0000, 64'd100, 64'd81, 64'd1};
  logic        t3_flt  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [64:0] t3_exp  [6] = '{{1'b0, 64'd4}, {1'b0, 64'd5}, {1'b1, 64'h0000_0000_4080_0000},
                              {1'b0, 64'd10}, {1'b0, 64'd9}, {1'b0, 64'd1}};

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst        = 1'b1;
    reqValid   = 1'b0;
    reqData    = 64'd0;
    reqIsFloat = 1'b0;
    respReady  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    // ---- float 4.0 with junk upper bits, core latency 10 ----
    core_lat   = 10;
    core_extra = 0;
    send(64'hFFFF_FFFF_4080_0000, 1'b1);
    reqValid = 1'b0;
    check_eq("t1_no_launch_yet", {64'd0, coreInputStable}, 65'd0);
    @(negedge clk);
    check_eq("t1_launch_T2", {64'd0, coreInputStable}, 65'd1);
    check_eq("t1_coreIn", {coreIsFloat, coreIn}, {1'b1, 64'h0000_0000_4080_0000});
    @(negedge clk);
    check_eq("t1_pulse_1cyc", {64'd0, coreInputStable}, 65'd0);
    wait_resp("t1_resp_timeout");
    check_eq("t1_resp", {respIsFloat, respData}, {1'b1, 64'h0000_0000_4000_0000});
    check_eq("t1_ack", {64'd0, coreResultAck}, 65'd1);
    check_eq("t1_coreIn_held", {coreIsFloat, coreIn}, {1'b1, 64'h0000_0000_4080_0000});
    take_resp();
    check_eq("t1_resp_cleared", {64'd0, respValid}, 65'd0);

    // ---- integer 144 ----
    send(64'd144, 1'b0);
    reqValid = 1'b0;
    wait_resp("t2_resp_timeout");
    check_eq("t2_resp", {respIsFloat, respData}, {1'b0, 64'd12});
    check_eq("t2_ack_high", {64'd0, coreResultAck}, 65'd1);
    @(negedge clk);
    check_eq("t2_ack_drop", {64'd0, coreResultAck}, 65'd0);
    check_eq("t2_busy_idle", {64'd0, busy}, 65'd0);
    take_resp();

    // ---- back-pressure: 6 requests with respReady held low ----
    core_lat = 3;
    resp_q.delete();
    base = launch_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) send(t3_data[i], t3_flt[i]);
        reqValid = 1'b0;
      end
    join_none
    wait_resp("t3_resp_timeout");
    repeat (5) @(negedge clk);
    check_eq("t3_full_reqReady", {64'd0, reqReady}, 65'd0);
    check_eq("t3_one_launch", 65'(launch_cnt - base), 65'd1);
    repeat (20) @(negedge clk);
    check_eq("t3_no_second_launch", 65'(launch_cnt - base), 65'd1);
    check_eq("t3_head_resp", {respIsFloat, respData}, {1'b0, 64'd4});
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
    check_eq("t3_pop_cycle_refused", {64'd0, reqReady}, 65'd0);
    check_eq("t3_pop_cycle_no_pulse", {64'd0, coreInputStable}, 65'd0);
    @(negedge clk);
    check_eq("t3_launch_reqReady", {63'd0, coreInputStable, reqReady}, 65'd3);
    @(negedge clk);
    check_eq("t3_refilled_full", {64'd0, reqReady}, 65'd0);
    respReady = 1'b1;
    n = 0;
    while (resp_q.size() < 6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("t3_resp_count", 65'(resp_q.size()), 65'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < resp_q.size()) check_eq($sformatf("t3_order_%0d", i), resp_q[i], t3_exp[i]);
    end

    // ---- latency 1, result held 2 extra cycles after ack ----
    repeat (3) @(negedge clk);
    core_lat   = 1;
    core_extra = 2;
    ack_cycles = 0;
    resp_rises = 0;
    resp_q.delete();
    send(64'd81, 1'b0);
    reqValid = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t4_ack_cycles", 65'(ack_cycles), 65'd3);
    check_eq("t4_single_capture", 65'(resp_rises), 65'd1);
    check_eq("t4_resp_count", 65'(resp_q.size()), 65'd1);
    if (resp_q.size() > 0) check_eq("t4_resp", resp_q[0], {1'b0, 64'd9});
    core_extra = 0;
    respReady  = 1'b0;

    // ---- reset during WAIT ----
    core_lat = 10;
    send(64'd100, 1'b0);
    reqValid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t5_busy_in_wait", {62'd0, busy, coreInputStable, coreResultStable}, 65'd4);
    rst = 1'b1;
    @(negedge clk);
    check_reset("t5");
    rst = 1'b0;
    resp_rises = 0;
    base = launch_cnt;
    @(negedge clk);
    force_stable = 1'b1;
    repeat (2) @(negedge clk);
    force_stable = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("t5_late_stable_ignored", {63'd0, respValid, coreResultAck}, 65'd0);
    check_eq("t5_no_resp_rise", 65'(resp_rises), 65'd0);
    check_eq("t5_no_launch", 65'(launch_cnt - base), 65'd0);
    check_eq("t5_idle", {64'd0, busy}, 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
